tcp_conn_ctrl: RTL and testbench
================================

Name: tcp_conn_ctrl

Overview:
- Single-connection TCP server controller. Sits after tcp_decode and ahead of the TCP/IP transmit path.
- Consumes each decoded segment and runs the passive-open / passive-close state machine. Tracks snd_nxt/rcv_nxt.
- Issues one response-segment request per accepted segment (SYN|ACK, ACK, FIN|ACK) over a req/ack handshake. Reports in-order payload to the application.

Parameters:
- LOCAL_PORT, 16'd80, TCP port served; all other dest ports are dropped.
- ISN, 32'h0000_1000, initial send sequence number.
- TIMEOUT, 24'd12_500_000, cycles without a qualifying segment in SYN_RCVD/LAST_ACK before returning to LISTEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_done  in  1  decoder done; level, high from end of segment until next segment start
- rx_err  in  1  decoder checksum error, valid while rx_done high
- rx_sport  in  16  decoded source port
- rx_dport  in  16  decoded dest port
- rx_seq  in  32  decoded sequence number
- rx_ack  in  32  decoded ack number
- rx_flags  in  8  decoded flags (bit0 FIN, bit1 SYN, bit2 RST, bit4 ACK)
- rx_ip_sa  in  32  IP source address of segment
- rx_payload_len  in  16  TCP payload bytes, computed upstream
- tx_req  out  1  response request
- tx_ack  in  1  tx path accepts request
- tx_flags  out  8  response flags
- tx_seq  out  32  response sequence number
- tx_acknum  out  32  response ack number
- tx_dport  out  16  peer port
- tx_da  out  32  peer IP
- app_valid  out  1  one-cycle pulse: in-order payload accepted
- app_len  out  16  payload length for app_valid
- conn_state  out  2  0 LISTEN, 1 SYN_RCVD, 2 ESTABLISHED, 3 LAST_ACK
- drop_count  out  8  saturating count of dropped segments

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; internal state LISTEN; snd_nxt=ISN; rcv_nxt=0; timer=0. Reset mid-handshake drops tx_req immediately.
- Segment event: rising edge of rx_done (registered edge detect). Input fields are sampled on that cycle.
- A segment is qualified when rx_err=0 and rx_dport=LOCAL_PORT. When not in LISTEN it must also match the latched peer: rx_ip_sa=tx_da and rx_sport=tx_dport.
- Drops:
  - Unqualified events are dropped and drop_count is incremented.
  - An event arriving while tx_req=1 is dropped and counted; it never queues.
  - drop_count saturates at 255.
- Tx handshake:
  - tx_req rises the cycle after the event, with all tx_* fields stable.
  - The transfer completes on the cycle where tx_req&tx_ack=1; tx_req falls the next cycle.
  - No timeout on tx_ack.
- Arithmetic: all sequence arithmetic is modulo 2^32 (wraps).
- LISTEN:
  - Qualified SYN with ACK=0 and RST=0: latch peer IP/port; rcv_nxt=rx_seq+1; request SYN|ACK (8'h12, seq=ISN, ack=rcv_nxt); snd_nxt=ISN+1; go to SYN_RCVD.
  - Anything else: stay in LISTEN, no tx, not counted.
- SYN_RCVD:
  - RST: go to LISTEN.
  - ACK with rx_ack=snd_nxt: go to ESTABLISHED, no tx.
  - Other: ignore.
- ESTABLISHED:
  - RST: go to LISTEN, no tx.
  - rx_seq≠rcv_nxt: duplicate ACK (8'h10, seq=snd_nxt, ack=rcv_nxt); no state change; app_valid stays 0.
  - rx_seq=rcv_nxt and payload>0: rcv_nxt+=len; app_valid pulse with app_len=len, coincident with tx_req rise.
  - FIN also set: rcv_nxt+=1 after the payload add; request FIN|ACK (8'h11, seq=snd_nxt); snd_nxt+=1; go to LAST_ACK.
  - Else, if payload>0: request ACK (8'h10).
  - Pure ACK with no payload and no FIN: no tx.
- LAST_ACK:
  - ACK with rx_ack=snd_nxt, or RST: go to LISTEN.
  - Re-sent FIN: re-request FIN|ACK using snd_nxt-1.
- Timer:
  - Counts only in SYN_RCVD and LAST_ACK; cleared on every qualified event and on every state change.
  - Reaching TIMEOUT-1 forces LISTEN the next cycle.
  - Timeout coincident with a qualified event: the event wins.
- Returning to LISTEN clears snd_nxt to ISN. An outstanding tx_req continues until acknowledged.
- conn_state reflects the registered state.

Test Plan:
- Handshake: SYN from 10.0.0.2:5000 seq=0x100 to port 80, tx_ack one cycle after tx_req -> tx 8'h12 seq=0x1000 ack=0x101, state 1. Then ACK ack=0x1001 -> state 2, no tx.
- Data (from ESTABLISHED): seq=0x101 len=10 -> app_valid with app_len=10, tx 8'h10 ack=0x10B. Then seq=0x101 again -> dup ACK ack=0x10B, no app_valid.
- Close: FIN seq=0x10B len=0 -> tx 8'h11 seq=0x1001 ack=0x10C, state 3. ACK ack=0x1002 -> state 0.
- Timeout (TIMEOUT=16 sim): SYN, then no traffic -> state 0 exactly 16 cycles after entering SYN_RCVD.
- Drops:
  - rx_err=1 SYN -> no tx, drop_count 1.
  - dport 81 -> drop_count 2.
  - Second segment while tx_ack held low -> drop_count 3, tx fields unchanged.
- Reset and wrap:
  - rst_n low during SYN_RCVD with tx_req high -> all outputs 0 asynchronously, state 0.
  - SYN seq=32'hFFFF_FFFF -> ack=0.

Source files
------------

// File: rtl/tcp_conn_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : tcp_conn_ctrl_if
//  Purpose  : Bundles the decoded-segment inputs, the transmit request
//             handshake and the application/status outputs of tcp_conn_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
interface tcp_conn_ctrl_if;
    // Decoded segment from tcp_decode
    logic        rx_done;
    logic        rx_err;
    logic [15:0] rx_sport;
    logic [15:0] rx_dport;
    logic [31:0] rx_seq;
    logic [31:0] rx_ack;
    logic [7:0]  rx_flags;
    logic [31:0] rx_ip_sa;
    logic [15:0] rx_payload_len;

    // Response request towards the transmit path
    logic        tx_req;
    logic        tx_ack;
    logic [7:0]  tx_flags;
    logic [31:0] tx_seq;
    logic [31:0] tx_acknum;
    logic [15:0] tx_dport;
    logic [31:0] tx_da;

    // Application and status
    logic        app_valid;
    logic [15:0] app_len;
    logic [1:0]  conn_state;
    logic [7:0]  drop_count;

    // Environment side: decoder, transmit path and application
    modport master (
        output rx_done, rx_err, rx_sport, rx_dport, rx_seq, rx_ack,
               rx_flags, rx_ip_sa, rx_payload_len, tx_ack,
        input  tx_req, tx_flags, tx_seq, tx_acknum, tx_dport, tx_da,
               app_valid, app_len, conn_state, drop_count
    );

    // Connection controller side
    modport slave (
        input  rx_done, rx_err, rx_sport, rx_dport, rx_seq, rx_ack,
               rx_flags, rx_ip_sa, rx_payload_len, tx_ack,
        output tx_req, tx_flags, tx_seq, tx_acknum, tx_dport, tx_da,
               app_valid, app_len, conn_state, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/tcp_conn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tcp_conn_ctrl
//  Purpose  : Single-connection TCP server controller. Runs passive open /
//             passive close, tracks snd_nxt/rcv_nxt, requests one response
//             segment per accepted segment and reports in-order payload.
//  Revision : 1.0 - initial release
// ============================================================================
module tcp_conn_ctrl #(
    parameter logic [15:0] LOCAL_PORT = 16'd80,
    parameter logic [31:0] ISN        = 32'h0000_1000,
    parameter logic [23:0] TIMEOUT    = 24'd12_500_000
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    tcp_conn_ctrl_if.slave bus
);

    localparam logic [1:0] c_listen      = 2'd0;
    localparam logic [1:0] c_syn_rcvd    = 2'd1;
    localparam logic [1:0] c_established = 2'd2;
    localparam logic [1:0] c_last_ack    = 2'd3;

    localparam logic [7:0] c_flags_ack    = 8'h10;
    localparam logic [7:0] c_flags_finack = 8'h11;
    localparam logic [7:0] c_flags_synack = 8'h12;

    logic [1:0]  r_state;
    logic [31:0] r_snd_nxt;
    logic [31:0] r_rcv_nxt;
    logic [23:0] r_timer;
    logic        r_done_d;
    logic        r_tx_req;
    logic [7:0]  r_tx_flags;
    logic [31:0] r_tx_seq;
    logic [31:0] r_tx_acknum;
    logic [15:0] r_tx_dport;
    logic [31:0] r_tx_da;
    logic        r_app_valid;
    logic [15:0] r_app_len;
    logic [7:0]  r_drop_count;

    logic        w_fin;
    logic        w_syn;
    logic        w_rst;
    logic        w_ackf;
    logic        w_unused_flags;
    logic        w_event;
    logic        w_port_ok;
    logic        w_peer_ok;
    logic        w_qual_evt;
    logic        w_accept;
    logic        w_drop;
    logic        w_timer_on;
    logic        w_timeout;
    logic [31:0] w_rcv_data;

    logic [1:0]  w_state_nx;
    logic [31:0] w_snd_nx;
    logic [31:0] w_rcv_nx;
    logic        w_send;
    logic [7:0]  w_send_flags;
    logic [31:0] w_send_seq;
    logic [31:0] w_send_ack;
    logic        w_latch_peer;
    logic        w_app;

    assign w_fin  = bus.rx_flags[0];
    assign w_syn  = bus.rx_flags[1];
    assign w_rst  = bus.rx_flags[2];
    assign w_ackf = bus.rx_flags[4];
    // PSH/URG/ECE/CWR carry no meaning for this controller
    assign w_unused_flags = ^{bus.rx_flags[7:5], bus.rx_flags[3]};

    // A segment is seen once, on the rising edge of the level-type done flag
    assign w_event   = bus.rx_done & ~r_done_d;
    assign w_port_ok = ~bus.rx_err & (bus.rx_dport == LOCAL_PORT);
    // Outside LISTEN only the latched peer may talk to us
    assign w_peer_ok = (r_state == c_listen) |
                       ((bus.rx_ip_sa == r_tx_da) & (bus.rx_sport == r_tx_dport));
    assign w_qual_evt = w_event & w_port_ok & w_peer_ok;
    // A busy request slot discards the segment rather than queueing it
    assign w_accept   = w_qual_evt & ~r_tx_req;
    assign w_drop     = w_event & (~(w_port_ok & w_peer_ok) | r_tx_req);

    assign w_timer_on = (r_state == c_syn_rcvd) | (r_state == c_last_ack);
    // A qualified segment in the same cycle takes priority over the timeout
    assign w_timeout  = w_timer_on & (r_timer == (TIMEOUT - 24'd1)) & ~w_qual_evt;
    assign w_rcv_data = r_rcv_nxt + {16'd0, bus.rx_payload_len};

    // Next-state, sequence tracking and response selection for one segment
    always_comb begin
        w_state_nx   = r_state;
        w_snd_nx     = r_snd_nxt;
        w_rcv_nx     = r_rcv_nxt;
        w_send       = 1'b0;
        w_send_flags = c_flags_ack;
        w_send_seq   = r_snd_nxt;
        w_send_ack   = r_rcv_nxt;
        w_latch_peer = 1'b0;
        w_app        = 1'b0;
        if (w_accept) begin
            case (r_state)
                c_listen: begin
                    if (w_syn & ~w_ackf & ~w_rst) begin
                        w_latch_peer = 1'b1;
                        w_rcv_nx     = bus.rx_seq + 32'd1;
                        w_send       = 1'b1;
                        w_send_flags = c_flags_synack;
                        w_send_seq   = ISN;
                        w_send_ack   = bus.rx_seq + 32'd1;
                        w_snd_nx     = ISN + 32'd1;
                        w_state_nx   = c_syn_rcvd;
                    end
                end
                c_syn_rcvd: begin
                    if (w_rst) begin
                        w_state_nx = c_listen;
                    end else if (w_ackf && (bus.rx_ack == r_snd_nxt)) begin
                        w_state_nx = c_established;
                    end
                end
                c_established: begin
                    if (w_rst) begin
                        w_state_nx = c_listen;
                    end else if (bus.rx_seq != r_rcv_nxt) begin
                        // Out-of-order or duplicate: re-advertise what we expect
                        w_send = 1'b1;
                    end else begin
                        w_app = (bus.rx_payload_len != 16'd0);
                        if (w_fin) begin
                            w_rcv_nx     = w_rcv_data + 32'd1;
                            w_send       = 1'b1;
                            w_send_flags = c_flags_finack;
                            w_send_ack   = w_rcv_data + 32'd1;
                            w_snd_nx     = r_snd_nxt + 32'd1;
                            w_state_nx   = c_last_ack;
                        end else if (bus.rx_payload_len != 16'd0) begin
                            w_rcv_nx   = w_rcv_data;
                            w_send     = 1'b1;
                            w_send_ack = w_rcv_data;
                        end
                    end
                end
                default: begin
                    if ((w_ackf && (bus.rx_ack == r_snd_nxt)) || w_rst) begin
                        w_state_nx = c_listen;
                    end else if (w_fin) begin
                        // Peer missed our FIN|ACK: resend it with the original seq
                        w_send       = 1'b1;
                        w_send_flags = c_flags_finack;
                        w_send_seq   = r_snd_nxt - 32'd1;
                    end
                end
            endcase
        end else if (w_timeout) begin
            w_state_nx = c_listen;
        end
        if ((w_state_nx == c_listen) && (r_state != c_listen)) begin
            w_snd_nx = ISN;
        end
    end

    // Connection state, sequence numbers, timer and edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_listen;
            r_snd_nxt <= ISN;
            r_rcv_nxt <= 32'd0;
            r_timer   <= 24'd0;
            r_done_d  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_snd_nxt <= w_snd_nx;
            r_rcv_nxt <= w_rcv_nx;
            r_done_d  <= bus.rx_done;
            if ((w_state_nx != r_state) || w_qual_evt) begin
                r_timer <= 24'd0;
            end else if (w_timer_on) begin
                r_timer <= r_timer + 24'd1;
            end
        end
    end

    // Response request handshake and latched peer address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_req    <= 1'b0;
            r_tx_flags  <= 8'd0;
            r_tx_seq    <= 32'd0;
            r_tx_acknum <= 32'd0;
            r_tx_dport  <= 16'd0;
            r_tx_da     <= 32'd0;
        end else begin
            if (w_send) begin
                r_tx_req    <= 1'b1;
                r_tx_flags  <= w_send_flags;
                r_tx_seq    <= w_send_seq;
                r_tx_acknum <= w_send_ack;
            end else if (r_tx_req && bus.tx_ack) begin
                r_tx_req <= 1'b0;
            end
            if (w_latch_peer) begin
                r_tx_dport <= bus.rx_sport;
                r_tx_da    <= bus.rx_ip_sa;
            end
        end
    end

    // Application payload pulse and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_app_valid  <= 1'b0;
            r_app_len    <= 16'd0;
            r_drop_count <= 8'd0;
        end else begin
            r_app_valid <= w_app;
            if (w_app) begin
                r_app_len <= bus.rx_payload_len;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign bus.tx_req     = r_tx_req;
    assign bus.tx_flags   = r_tx_flags;
    assign bus.tx_seq     = r_tx_seq;
    assign bus.tx_acknum  = r_tx_acknum;
    assign bus.tx_dport   = r_tx_dport;
    assign bus.tx_da      = r_tx_da;
    assign bus.app_valid  = r_app_valid;
    assign bus.app_len    = r_app_len;
    assign bus.conn_state = r_state;
    assign bus.drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_tcp_conn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tcp_conn_ctrl
//  Purpose  : Directed self-checking bench for tcp_conn_ctrl: handshake,
//             data, duplicate ACK, close, timeout, drops, reset and wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tcp_conn_ctrl;

    localparam logic [31:0] c_peer_ip   = 32'h0A00_0002;
    localparam logic [15:0] c_peer_port = 16'd5000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tcp_conn_ctrl_if bus ();

    tcp_conn_ctrl #(
        .LOCAL_PORT (16'd80),
        .ISN        (32'h0000_1000),
        .TIMEOUT    (24'd16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Single comparison point: counts and reports
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present one segment from the peer; returns #1 after the event edge
    task automatic send_seg(input logic [15:0] dport, input logic [31:0] seq,
                            input logic [31:0] ack, input logic [7:0] flags,
                            input logic [15:0] len, input logic err);
        @(negedge clk);
        bus.rx_done = 1'b0;
        @(negedge clk);
        bus.rx_sport       = c_peer_port;
        bus.rx_dport       = dport;
        bus.rx_seq         = seq;
        bus.rx_ack         = ack;
        bus.rx_flags       = flags;
        bus.rx_ip_sa       = c_peer_ip;
        bus.rx_payload_len = len;
        bus.rx_err         = err;
        bus.rx_done        = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Accept the pending request one cycle after it is seen
    task automatic do_handshake(input string tag);
        int n = 0;
        while (!bus.tx_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_req_seen"}, {31'd0, bus.tx_req}, 32'd1);
        @(negedge clk);
        bus.tx_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_ack = 1'b0;
        check_eq({tag, "_req_fall"}, {31'd0, bus.tx_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_done = 1'b0;
        bus.rx_err = 1'b0;
        bus.rx_sport = '0;
        bus.rx_dport = '0;
        bus.rx_seq = '0;
        bus.rx_ack = '0;
        bus.rx_flags = '0;
        bus.rx_ip_sa = '0;
        bus.rx_payload_len = '0;
        bus.tx_ack = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", {30'd0, bus.conn_state}, 32'd0);
        check_eq("rst_tx_req", {31'd0, bus.tx_req}, 32'd0);
        check_eq("rst_drop", {24'd0, bus.drop_count}, 32'd0);
        check_eq("rst_app_valid", {31'd0, bus.app_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Checksum error and wrong port are counted, no response
        send_seg(16'd80, 32'h100, 32'h0, 8'h02, 16'd0, 1'b1);
        check_eq("err_tx_req", {31'd0, bus.tx_req}, 32'd0);
        check_eq("err_drop", {24'd0, bus.drop_count}, 32'd1);
        check_eq("err_state", {30'd0, bus.conn_state}, 32'd0);
        send_seg(16'd81, 32'h100, 32'h0, 8'h02, 16'd0, 1'b0);
        check_eq("port_tx_req", {31'd0, bus.tx_req}, 32'd0);
        check_eq("port_drop", {24'd0, bus.drop_count}, 32'd2);

        // Passive open
        send_seg(16'd80, 32'h100, 32'h0, 8'h02, 16'd0, 1'b0);
        check_eq("syn_tx_req", {31'd0, bus.tx_req}, 32'd1);
        check_eq("syn_flags", {24'd0, bus.tx_flags}, 32'h12);
        check_eq("syn_seq", bus.tx_seq, 32'h1000);
        check_eq("syn_acknum", bus.tx_acknum, 32'h101);
        check_eq("syn_dport", {16'd0, bus.tx_dport}, 32'd5000);
        check_eq("syn_da", bus.tx_da, c_peer_ip);
        check_eq("syn_state", {30'd0, bus.conn_state}, 32'd1);

        // Segment while the request is still pending is dropped
        send_seg(16'd80, 32'h100, 32'h0, 8'h02, 16'd0, 1'b0);
        check_eq("busy_drop", {24'd0, bus.drop_count}, 32'd3);
        check_eq("busy_tx_req", {31'd0, bus.tx_req}, 32'd1);
        check_eq("busy_flags", {24'd0, bus.tx_flags}, 32'h12);
        check_eq("busy_acknum", bus.tx_acknum, 32'h101);
        do_handshake("synack");

        send_seg(16'd80, 32'h101, 32'h1001, 8'h10, 16'd0, 1'b0);
        check_eq("est_state", {30'd0, bus.conn_state}, 32'd2);
        check_eq("est_no_tx", {31'd0, bus.tx_req}, 32'd0);

        // In-order data
        send_seg(16'd80, 32'h101, 32'h1001, 8'h10, 16'd10, 1'b0);
        check_eq("data_app_valid", {31'd0, bus.app_valid}, 32'd1);
        check_eq("data_app_len", {16'd0, bus.app_len}, 32'd10);
        check_eq("data_tx_req", {31'd0, bus.tx_req}, 32'd1);
        check_eq("data_flags", {24'd0, bus.tx_flags}, 32'h10);
        check_eq("data_seq", bus.tx_seq, 32'h1001);
        check_eq("data_acknum", bus.tx_acknum, 32'h10B);
        do_handshake("data");
        check_eq("data_app_pulse", {31'd0, bus.app_valid}, 32'd0);

        // Duplicate segment
        send_seg(16'd80, 32'h101, 32'h1001, 8'h10, 16'd10, 1'b0);
        check_eq("dup_tx_req", {31'd0, bus.tx_req}, 32'd1);
        check_eq("dup_flags", {24'd0, bus.tx_flags}, 32'h10);
        check_eq("dup_acknum", bus.tx_acknum, 32'h10B);
        check_eq("dup_app_valid", {31'd0, bus.app_valid}, 32'd0);
        check_eq("dup_state", {30'd0, bus.conn_state}, 32'd2);
        do_handshake("dup");

        // Passive close
        send_seg(16'd80, 32'h10B, 32'h1001, 8'h11, 16'd0, 1'b0);
        check_eq("fin_flags", {24'd0, bus.tx_flags}, 32'h11);
        check_eq("fin_seq", bus.tx_seq, 32'h1001);
        check_eq("fin_acknum", bus.tx_acknum, 32'h10C);
        check_eq("fin_state", {30'd0, bus.conn_state}, 32'd3);
        check_eq("fin_app_valid", {31'd0, bus.app_valid}, 32'd0);
        do_handshake("finack");
        send_seg(16'd80, 32'h10C, 32'h1002, 8'h10, 16'd0, 1'b0);
        check_eq("close_state", {30'd0, bus.conn_state}, 32'd0);
        check_eq("close_no_tx", {31'd0, bus.tx_req}, 32'd0);

        // SYN_RCVD timeout: back to LISTEN 16 cycles after entry
        bus.tx_ack = 1'b1;
        send_seg(16'd80, 32'h200, 32'h0, 8'h02, 16'd0, 1'b0);
        check_eq("to_state_entry", {30'd0, bus.conn_state}, 32'd1);
        check_eq("to_acknum", bus.tx_acknum, 32'h201);
        repeat (15) @(posedge clk);
        #1;
        check_eq("to_state_15", {30'd0, bus.conn_state}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("to_state_16", {30'd0, bus.conn_state}, 32'd0);
        bus.tx_ack = 1'b0;

        // Sequence wrap, then asynchronous reset with tx_req pending
        send_seg(16'd80, 32'hFFFF_FFFF, 32'h0, 8'h02, 16'd0, 1'b0);
        check_eq("wrap_tx_req", {31'd0, bus.tx_req}, 32'd1);
        check_eq("wrap_flags", {24'd0, bus.tx_flags}, 32'h12);
        check_eq("wrap_acknum", bus.tx_acknum, 32'h0);
        check_eq("wrap_state", {30'd0, bus.conn_state}, 32'd1);
        #2;
        rst_n = 1'b0;
        bus.rx_done = 1'b0;
        #1;
        check_eq("arst_tx_req", {31'd0, bus.tx_req}, 32'd0);
        check_eq("arst_state", {30'd0, bus.conn_state}, 32'd0);
        check_eq("arst_flags", {24'd0, bus.tx_flags}, 32'd0);
        check_eq("arst_seq", bus.tx_seq, 32'd0);
        check_eq("arst_da", bus.tx_da, 32'd0);
        check_eq("arst_drop", {24'd0, bus.drop_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_state", {30'd0, bus.conn_state}, 32'd0);
        check_eq("post_rst_tx_req", {31'd0, bus.tx_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
